// File: rtl/tick_sched_ctrl_pkg.sv
// Shared definitions for the timebase controller: mode encoding, strobe bundle, counter sizing.
// The display and timekeeping blocks decode mode with the same encoding.
package tick_sched_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_SET   = 2'd2
    } mode_e;

    typedef struct packed {
        logic scan;
        logic sec;
        logic adv;
        logic blink;
    } strobe_t;

    // Counter width for a modulus; a modulus of 1 still needs one storage bit.
    function automatic int unsigned cnt_w(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/tick_sched_ctrl_tick_gen.sv
// Modulo-MOD counter with enable and synchronous clear; tick_c_o flags the enabled wrap cycle.
// The tick is combinational so instances can be cascaded on the same edge.
module tick_gen
    import tick_sched_ctrl_pkg::*;
#(
    parameter int unsigned MOD = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c_o
);

    localparam int unsigned   CW   = cnt_w(MOD);
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable; wrap compares against MOD-1 so the count never overflows.
    always_comb begin
        cnt_d    = cnt_q;
        tick_c_o = en_i && !clr_i && (cnt_q == LAST);
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Central timebase: one prescaler feeds scan, seconds, blink and fast-advance enables,
// gated by the RUN/PAUSE/SET mode sequencer. All outputs are clk_in-domain registered strobes.
module tick_sched_ctrl
    import tick_sched_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 1_000,
    parameter int unsigned FAST_HZ = 8
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       run_req,
    input  logic       pause_req,
    input  logic       set_req,
    input  logic       inc_req,
    input  logic       fast_en,
    output logic       scan_tick,
    output logic       sec_tick,
    output logic       adv_tick,
    output logic       blink,
    output logic [1:0] mode
);

    localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
    localparam int unsigned SUB_MOD   = SCAN_HZ;
    localparam int unsigned BLINK_MOD = SCAN_HZ / 2;
    localparam int unsigned FAST_MOD  = SCAN_HZ / FAST_HZ;

    if ((CLK_HZ % SCAN_HZ) != 0 || (SCAN_HZ % 2) != 0 || (SCAN_HZ % FAST_HZ) != 0) begin : g_bad_params
        $error("tick_sched_ctrl: CLK_HZ/SCAN_HZ/FAST_HZ ratios must be integral and SCAN_HZ even");
    end

    mode_e   state_q;
    mode_e   state_d;
    strobe_t strobe_q;
    strobe_t strobe_d;

    logic in_run;
    logic in_set;
    logic pre_tick_c;
    logic sub_tick_c;
    logic blink_tick_c;
    logic fast_tick_c;

    assign in_run = (state_q == MODE_RUN);
    assign in_set = (state_q == MODE_SET);

    // Shared prescaler: free-running in every mode.
    tick_gen #(.MOD(DIV)) u_pre (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en_i     (1'b1),
        .clr_i    (1'b0),
        .tick_c_o (pre_tick_c)
    );

    // Sub-second phase: frozen in PAUSE, held clear in SET so RUN restarts a full second.
    tick_gen #(.MOD(SUB_MOD)) u_sub (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en_i     (pre_tick_c && in_run),
        .clr_i    (in_set),
        .tick_c_o (sub_tick_c)
    );

    tick_gen #(.MOD(BLINK_MOD)) u_blink (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en_i     (pre_tick_c && in_set),
        .clr_i    (state_d != MODE_SET),
        .tick_c_o (blink_tick_c)
    );

    // Fast-advance phase restarts whenever fast_en drops or SET is left.
    tick_gen #(.MOD(FAST_MOD)) u_fast (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en_i     (pre_tick_c && in_set && fast_en),
        .clr_i    (!(in_set && fast_en)),
        .tick_c_o (fast_tick_c)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Request priority: set_req, then pause_req, then run_req.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN: begin
                if (set_req)        state_d = MODE_SET;
                else if (pause_req) state_d = MODE_PAUSE;
            end
            MODE_PAUSE: begin
                if (set_req)      state_d = MODE_SET;
                else if (run_req) state_d = MODE_RUN;
            end
            MODE_SET: begin
                if (set_req || run_req) state_d = MODE_RUN;
            end
            default: state_d = MODE_RUN;
        endcase
    end

    // Strobe gating uses the current state; blink follows the next state so it reads 1 on SET exit.
    always_comb begin
        strobe_d       = '0;
        strobe_d.blink = 1'b1;
        strobe_d.scan  = pre_tick_c;
        strobe_d.sec   = sub_tick_c;
        strobe_d.adv   = in_set && (inc_req || fast_tick_c);
        if (state_d == MODE_SET) begin
            strobe_d.blink = strobe_q.blink ^ blink_tick_c;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= '{scan: 1'b0, sec: 1'b0, adv: 1'b0, blink: 1'b1};
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign scan_tick = strobe_q.scan;
    assign sec_tick  = strobe_q.sec;
    assign adv_tick  = strobe_q.adv;
    assign blink     = strobe_q.blink;
    assign mode      = state_q;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed bench for tick_sched_ctrl at CLK_HZ=40, SCAN_HZ=10, FAST_HZ=5 (DIV=4, 1 s = 40 cycles).
// Vector cycle N means "after the N-th rising edge since reset release"; requests apply at that edge.
module tb_tick_sched_ctrl;

    logic       clk_in;
    logic       rst_n;
    logic       run_req;
    logic       pause_req;
    logic       set_req;
    logic       inc_req;
    logic       fast_en;
    logic       scan_tick;
    logic       sec_tick;
    logic       adv_tick;
    logic       blink;
    logic [1:0] mode;

    tick_sched_ctrl #(
        .CLK_HZ  (40),
        .SCAN_HZ (10),
        .FAST_HZ (5)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .run_req   (run_req),
        .pause_req (pause_req),
        .set_req   (set_req),
        .inc_req   (inc_req),
        .fast_en   (fast_en),
        .scan_tick (scan_tick),
        .sec_tick  (sec_tick),
        .adv_tick  (adv_tick),
        .blink     (blink),
        .mode      (mode)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // exp = {scan, sec, adv, blink, mode[1:0]}
    typedef struct {
        int         scn;
        int         cyc;
        logic       run;
        logic       pause;
        logic       set;
        logic       inc;
        logic       fast;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n_scan;
    int   n_sec;
    int   n_adv;

    task automatic add(input int scn, input int c, input logic r, input logic p, input logic s,
                       input logic i, input logic f, input logic [5:0] e);
        vec_t v;
        v.scn = scn; v.cyc = c; v.run = r; v.pause = p; v.set = s; v.inc = i; v.fast = f; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {scan_tick, sec_tick, adv_tick, blink, mode};
    endfunction

    task automatic step();
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        n_scan += int'(scan_tick);
        n_sec  += int'(sec_tick);
        n_adv  += int'(adv_tick);
    endtask

    task automatic clear_counts();
        cyc = 0; n_scan = 0; n_sec = 0; n_adv = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        run_req = 0; pause_req = 0; set_req = 0; inc_req = 0; fast_en = 0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        clear_counts();
    endtask

    task automatic run_scn(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].scn == s) begin
                while (cyc < vecs[i].cyc - 1) step();
                run_req   = vecs[i].run;
                pause_req = vecs[i].pause;
                set_req   = vecs[i].set;
                inc_req   = vecs[i].inc;
                fast_en   = vecs[i].fast;
                step();
                run_req = 0; pause_req = 0; set_req = 0; inc_req = 0;
                n_cmp++;
                if (outs() !== vecs[i].exp) begin
                    n_err++;
                    $display("FAIL vec scn%0d cyc%0d: got {scan,sec,adv,blink,mode}=%b, expected %b",
                             s, cyc, outs(), vecs[i].exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        run_req = 0; pause_req = 0; set_req = 0; inc_req = 0; fast_en = 0;
        clear_counts();

        // 0: idle RUN after reset
        add(0,   1, 0,0,0,0,0, 6'b000100);
        add(0,   3, 0,0,0,0,0, 6'b000100);
        add(0,   4, 0,0,0,0,0, 6'b100100);
        add(0,   5, 0,0,0,0,0, 6'b000100);
        add(0,   8, 0,0,0,0,0, 6'b100100);
        add(0,  39, 0,0,0,0,0, 6'b000100);
        add(0,  40, 0,0,0,0,0, 6'b110100);
        add(0,  41, 0,0,0,0,0, 6'b000100);
        add(0,  80, 0,0,0,0,0, 6'b110100);
        // 1: pause at 20, run at 60, phase kept
        add(1,  20, 0,1,0,0,0, 6'b100101);
        add(1,  40, 0,0,0,0,0, 6'b100101);
        add(1,  60, 1,0,0,0,0, 6'b100100);
        add(1,  76, 0,0,0,0,0, 6'b100100);
        add(1,  79, 0,0,0,0,0, 6'b000100);
        add(1,  80, 0,0,0,0,0, 6'b110100);
        // 2: SET 20..100, blink and fresh second on exit
        add(2,  20, 0,0,1,0,0, 6'b100110);
        add(2,  39, 0,0,0,0,0, 6'b000110);
        add(2,  40, 0,0,0,0,0, 6'b100010);
        add(2,  59, 0,0,0,0,0, 6'b000010);
        add(2,  60, 0,0,0,0,0, 6'b100110);
        add(2,  80, 0,0,0,0,0, 6'b100010);
        add(2, 100, 0,0,1,0,0, 6'b100100);
        add(2, 139, 0,0,0,0,0, 6'b000100);
        add(2, 140, 0,0,0,0,0, 6'b110100);
        // 3: fast advance, single inc, merged inc+fast edge
        add(3,  10, 0,0,1,0,0, 6'b000110);
        add(3,  13, 0,0,0,0,1, 6'b000110);
        add(3,  19, 0,0,0,0,1, 6'b000110);
        add(3,  20, 0,0,0,0,1, 6'b101110);
        add(3,  21, 0,0,0,0,1, 6'b000110);
        add(3,  28, 0,0,0,0,1, 6'b101010);
        add(3,  52, 0,0,0,0,1, 6'b101110);
        add(3,  53, 0,0,0,0,0, 6'b000110);
        add(3,  60, 0,0,0,0,0, 6'b100110);
        add(3,  62, 0,0,0,1,0, 6'b001110);
        add(3,  63, 0,0,0,0,0, 6'b000110);
        add(3,  65, 0,0,0,0,1, 6'b000110);
        add(3,  72, 0,0,0,1,1, 6'b101010);
        add(3,  73, 0,0,0,0,1, 6'b000010);
        // 4: inc/fast ignored in RUN, set+pause together -> SET
        add(4,   6, 0,0,0,1,1, 6'b000100);
        add(4,   9, 0,0,0,0,1, 6'b000100);
        add(4,  11, 0,1,1,0,0, 6'b000110);
        add(4,  30, 0,0,0,0,0, 6'b000010);
        // 5: timing restart after mid-SET reset
        add(5,   3, 0,0,0,0,0, 6'b000100);
        add(5,   4, 0,0,0,0,0, 6'b100100);
        add(5,  40, 0,0,0,0,0, 6'b110100);

        do_reset();
        chk("reset_outs", int'(outs()), int'(6'b000100));
        run_scn(0);
        chk("idle_scan_count", n_scan, 20);
        chk("idle_sec_count", n_sec, 2);
        chk("idle_adv_count", n_adv, 0);

        do_reset();
        run_scn(1);
        chk("pause_scan_count", n_scan, 20);
        chk("pause_sec_count", n_sec, 1);

        do_reset();
        run_scn(2);
        chk("set_scan_count", n_scan, 35);
        chk("set_sec_count", n_sec, 1);
        chk("set_adv_count", n_adv, 0);

        do_reset();
        run_scn(3);
        chk("fast_adv_count", n_adv, 7);
        chk("fast_sec_count", n_sec, 0);

        do_reset();
        run_scn(4);
        chk("run_ign_adv_count", n_adv, 0);
        chk("run_ign_sec_count", n_sec, 0);

        // Asynchronous reset while in SET with blink low.
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", int'(outs()), int'(6'b000100));
        repeat (3) @(negedge clk_in);
        chk("held_rst_outs", int'(outs()), int'(6'b000100));
        rst_n = 1'b1;
        clear_counts();
        run_scn(5);
        chk("post_rst_scan_count", n_scan, 10);
        chk("post_rst_sec_count", n_sec, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
